// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// Optional register after every prefix level (PIPE=1), always an output register.
module pipelined_prefix_adder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LEVELS = 3,
    parameter int unsigned PIPE   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry_out,
    output logic             overflow
);

    if (WIDTH < 2 || LEVELS < 1 || WIDTH > (1 << LEVELS) ||
        WIDTH <= (1 << (LEVELS - 1)) || PIPE > 1) begin : g_bad_params
        $error("pipelined_prefix_adder: need WIDTH>=2, 2^(LEVELS-1) < WIDTH <= 2^LEVELS, PIPE in {0,1}");
    end

    // One pipeline stage: valid bit, carry in, half-sum bits and prefix (G,P).
    typedef struct packed {
        logic             vld;
        logic             cin;
        logic [WIDTH-1:0] hp;
        logic [WIDTH-1:0] gg;
        logic [WIDTH-1:0] pp;
    } stage_t;

    stage_t           stage_q [1:LEVELS];
    stage_t           stage_d [1:LEVELS];
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             advance;

    // One Kogge-Stone level: combine each bit with the group span bits below it.
    function automatic stage_t prefix_level(input stage_t s, input int unsigned span);
        stage_t r;
        r = s;
        for (int unsigned i = span; i < WIDTH; i++) begin
            r.gg[i] = s.gg[i] | (s.pp[i] & s.gg[i-span]);
            r.pp[i] = s.pp[i] & s.pp[i-span];
        end
        return r;
    endfunction

    // Whole pipeline moves together whenever the output slot is free or being drained.
    always_comb begin
        advance = out_ready | ~out_valid_q;
    end

    // Operand conditioning, prefix levels, sum/flag formation and stage hold logic.
    always_comb begin
        stage_t           cur;
        stage_t           nxt;
        logic [WIDTH-1:0] yv;
        logic [WIDTH:0]   c;

        yv      = sub ? ~y : y;
        cur.vld = in_valid;
        cur.cin = carry_in;
        cur.hp  = x ^ yv;
        cur.gg  = x & yv;
        cur.pp  = x ^ yv;
        // Carry-in generate at bit -1 is pre-merged into bit 0 (P[-1]=0), so the
        // prefix tree only spans bits 0..WIDTH-1 and LEVELS levels suffice.
        cur.gg[0] = (x[0] & yv[0]) | ((x[0] ^ yv[0]) & carry_in);
        cur.pp[0] = 1'b0;

        for (int unsigned k = 1; k <= LEVELS; k++) begin
            nxt        = prefix_level(cur, 32'd1 << (k - 1));
            stage_d[k] = advance ? nxt : stage_q[k];
            cur        = (PIPE != 0) ? stage_q[k] : nxt;
        end

        c[0]       = cur.cin;
        c[WIDTH:1] = cur.gg;

        out_valid_d = advance ? cur.vld                  : out_valid_q;
        z_d         = advance ? (cur.hp ^ c[WIDTH-1:0])  : z_q;
        carry_out_d = advance ? c[WIDTH]                 : carry_out_q;
        overflow_d  = advance ? (c[WIDTH-1] ^ c[WIDTH])  : overflow_q;
    end

    // State registers; reset empties the pipeline and clears the output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 1; k <= LEVELS; k++) begin
                stage_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            z_q         <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            for (int unsigned k = 1; k <= LEVELS; k++) begin
                stage_q[k] <= stage_d[k];
            end
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: directed cases on a 4-bit PIPE=1 instance,
// plus 8-bit PIPE=0 and PIPE=1 instances driven with random traffic.
module tb_pipelined_prefix_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4-bit, LEVELS=2, PIPE=1 (latency 3)
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic       a_cin, a_sub, a_co, a_ovf;
    logic [3:0] a_x, a_y, a_z;

    // 8-bit instances share operand inputs, each has its own ready
    logic       r_valid, r_cin, r_sub;
    logic [7:0] r_x, r_y;
    logic       b_in_ready, b_out_valid, b_out_ready, b_co, b_ovf;
    logic [7:0] b_z;
    logic       c_in_ready, c_out_valid, c_out_ready, c_co, c_ovf;
    logic [7:0] c_z;

    pipelined_prefix_adder #(.WIDTH(4), .LEVELS(2), .PIPE(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .x(a_x), .y(a_y), .carry_in(a_cin), .sub(a_sub),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .z(a_z), .carry_out(a_co), .overflow(a_ovf)
    );

    pipelined_prefix_adder #(.WIDTH(8), .LEVELS(3), .PIPE(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(r_valid), .in_ready(b_in_ready),
        .x(r_x), .y(r_y), .carry_in(r_cin), .sub(r_sub),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .z(b_z), .carry_out(b_co), .overflow(b_ovf)
    );

    pipelined_prefix_adder #(.WIDTH(8), .LEVELS(3), .PIPE(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(r_valid), .in_ready(c_in_ready),
        .x(r_x), .y(r_y), .carry_in(r_cin), .sub(r_sub),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .z(c_z), .carry_out(c_co), .overflow(c_ovf)
    );

    int n_asserts = 0;
    int n_fail    = 0;
    int a_out_cnt = 0;
    int b_in_cnt  = 0;
    int c_in_cnt  = 0;

    // Scoreboards hold {overflow, carry_out, z[7:0]}
    logic [9:0] a_sb[$];
    logic [9:0] b_sb[$];
    logic [9:0] c_sb[$];
    logic [9:0] a_e, b_e, c_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer sum; overflow from operand/result sign bits.
    function automatic logic [9:0] ref_add(input int unsigned w, input logic [7:0] xa,
                                           input logic [7:0] ya, input logic ci, input logic sb);
        int unsigned mask, yy, sum, zz;
        logic xs, ys, zs, co, ov;
        logic [7:0] z8;
        mask = (32'd1 << w) - 32'd1;
        yy   = sb ? ((~{24'd0, ya}) & mask) : {24'd0, ya};
        sum  = {24'd0, xa} + yy + {31'd0, ci};
        zz   = sum & mask;
        co   = sum[w];
        xs   = xa[w-1];
        ys   = yy[w-1];
        zs   = zz[w-1];
        ov   = (xs == ys) && (zs != xs);
        z8   = zz[7:0];
        return {ov, co, z8};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [3:0] xi, input logic [3:0] yi, input logic ci, input logic si);
        a_x = xi; a_y = yi; a_cin = ci; a_sub = si; a_in_valid = 1'b1;
    endtask

    task automatic expect_a(input string tag, input logic [3:0] ez, input logic eco, input logic eov);
        check({tag, "_valid"}, {31'd0, a_out_valid}, 1);
        check({tag, "_z"}, {28'd0, a_z}, {28'd0, ez});
        check({tag, "_co"}, {31'd0, a_co}, {31'd0, eco});
        check({tag, "_ovf"}, {31'd0, a_ovf}, {31'd0, eov});
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (a_sb.size() + b_sb.size() + c_sb.size()) != 0; i++) step();
        check("drain_empty", a_sb.size() + b_sb.size() + c_sb.size(), 0);
    endtask

    // Monitors: on the negedge before an edge, record acceptances and check transfers.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_out_valid && a_out_ready) begin
                if (a_sb.size() == 0) check("a_unexpected_out", {31'd0, a_out_valid}, 0);
                else begin
                    a_e = a_sb.pop_front();
                    check("a_result", {22'd0, a_ovf, a_co, 4'd0, a_z}, {22'd0, a_e});
                    a_out_cnt++;
                end
            end
            if (a_in_valid && a_in_ready)
                a_sb.push_back(ref_add(4, {4'd0, a_x}, {4'd0, a_y}, a_cin, a_sub));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (b_out_valid && b_out_ready) begin
                if (b_sb.size() == 0) check("b_unexpected_out", {31'd0, b_out_valid}, 0);
                else begin
                    b_e = b_sb.pop_front();
                    check("b_result", {22'd0, b_ovf, b_co, b_z}, {22'd0, b_e});
                end
            end
            if (r_valid && b_in_ready) begin
                b_sb.push_back(ref_add(8, r_x, r_y, r_cin, r_sub));
                b_in_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (c_out_valid && c_out_ready) begin
                if (c_sb.size() == 0) check("c_unexpected_out", {31'd0, c_out_valid}, 0);
                else begin
                    c_e = c_sb.pop_front();
                    check("c_result", {22'd0, c_ovf, c_co, c_z}, {22'd0, c_e});
                end
            end
            if (r_valid && c_in_ready) begin
                c_sb.push_back(ref_add(8, r_x, r_y, r_cin, r_sub));
                c_in_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] bx [6];
        logic [3:0] by [6];
        logic       bc [6];
        logic       bs [6];
        logic [6:0] held;
        int         sent;
        int         start_cnt;

        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_x = '0; a_y = '0; a_cin = 1'b0; a_sub = 1'b0;
        r_valid = 1'b0; r_x = '0; r_y = '0; r_cin = 1'b0; r_sub = 1'b0;
        b_out_ready = 1'b1; c_out_ready = 1'b1;
        #2;
        check("rst_a_out_valid", {31'd0, a_out_valid}, 0);
        check("rst_a_z", {28'd0, a_z}, 0);
        check("rst_a_co", {31'd0, a_co}, 0);
        check("rst_a_ovf", {31'd0, a_ovf}, 0);
        check("rst_a_in_ready", {31'd0, a_in_ready}, 1);
        check("rst_b_out_valid", {31'd0, b_out_valid}, 0);
        check("rst_c_out_valid", {31'd0, c_out_valid}, 0);
        step(); step();
        rst = 1'b0;

        // Single add, exact latency of 3
        drive_a(4'b0011, 4'b0101, 1'b0, 1'b0);
        step();
        a_in_valid = 1'b0;
        check("lat_edge1", {31'd0, a_out_valid}, 0);
        step();
        check("lat_edge2", {31'd0, a_out_valid}, 0);
        step();
        expect_a("add1", 4'b1000, 1'b0, 1'b1);
        step();
        check("add1_gone", {31'd0, a_out_valid}, 0);

        // Back-to-back adds with carry in
        drive_a(4'b0000, 4'b0101, 1'b1, 1'b0);
        step();
        drive_a(4'b1100, 4'b0100, 1'b1, 1'b0);
        step();
        a_in_valid = 1'b0;
        step();
        expect_a("add2", 4'b0110, 1'b0, 1'b0);
        step();
        expect_a("add3", 4'b0001, 1'b1, 1'b0);
        step();

        // Back-to-back subtracts
        drive_a(4'b0011, 4'b0101, 1'b1, 1'b1);
        step();
        drive_a(4'b1000, 4'b0001, 1'b1, 1'b1);
        step();
        a_in_valid = 1'b0;
        step();
        expect_a("sub1", 4'b1110, 1'b0, 1'b0);
        step();
        expect_a("sub2", 4'b0111, 1'b1, 1'b1);
        step();

        // Backpressure: 6-op stream, out_ready low for two cycles with output valid
        for (int i = 0; i < 6; i++) begin
            bx[i] = 4'($urandom); by[i] = 4'($urandom);
            bc[i] = 1'($urandom); bs[i] = 1'($urandom);
        end
        sent = 0;
        start_cnt = a_out_cnt;
        held = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            a_out_ready = (cyc == 3 || cyc == 4) ? 1'b0 : 1'b1;
            if (sent < 6) drive_a(bx[sent], by[sent], bc[sent], bs[sent]);
            else a_in_valid = 1'b0;
            #1;
            if (cyc == 4 || cyc == 5)
                check("bp_hold", {25'd0, a_out_valid, a_ovf, a_co, a_z}, {25'd0, held});
            if (cyc == 3 || cyc == 4) begin
                check("bp_valid", {31'd0, a_out_valid}, 1);
                check("bp_in_ready", {31'd0, a_in_ready}, 0);
                held = {a_out_valid, a_ovf, a_co, a_z};
            end
            if (a_in_valid && a_in_ready) sent++;
            step();
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        check("bp_all_out", a_out_cnt - start_cnt, 6);
        check("bp_sb_empty", a_sb.size(), 0);

        // Reset with results in flight and one on the output
        drive_a(4'b0111, 4'b0001, 1'b0, 1'b0);
        step();
        drive_a(4'b0010, 4'b0010, 1'b0, 1'b0);
        step();
        drive_a(4'b0001, 4'b0001, 1'b1, 1'b0);
        step();
        a_in_valid = 1'b0;
        check("rs_pre_valid", {31'd0, a_out_valid}, 1);
        #2;
        rst = 1'b1;
        a_sb.delete();
        #1;
        check("rs_valid", {31'd0, a_out_valid}, 0);
        check("rs_z", {28'd0, a_z}, 0);
        check("rs_co", {31'd0, a_co}, 0);
        check("rs_ovf", {31'd0, a_ovf}, 0);
        step();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rs_no_emerge", {31'd0, a_out_valid}, 0);
        end
        drive_a(4'b0101, 4'b0110, 1'b0, 1'b0);
        step();
        a_in_valid = 1'b0;
        step();
        check("rs_lat_edge2", {31'd0, a_out_valid}, 0);
        step();
        expect_a("rs_after", 4'b1011, 1'b0, 1'b1);
        step();

        // 8-bit PIPE=0: single-edge latency, full carry ripple
        r_x = 8'hFF; r_y = 8'h01; r_cin = 1'b0; r_sub = 1'b0; r_valid = 1'b1;
        step();
        r_valid = 1'b0;
        check("b_lat_valid", {31'd0, b_out_valid}, 1);
        check("b_ff_z", {24'd0, b_z}, 0);
        check("b_ff_co", {31'd0, b_co}, 1);
        check("b_ff_ovf", {31'd0, b_ovf}, 0);
        drain();

        // Random traffic with random backpressure on both 8-bit instances
        for (int cyc = 0; cyc < 5000 && (b_in_cnt < 1000 || c_in_cnt < 1000); cyc++) begin
            r_valid = ($urandom_range(0, 3) != 0);
            r_x = 8'($urandom); r_y = 8'($urandom);
            r_cin = 1'($urandom); r_sub = 1'($urandom);
            b_out_ready = ($urandom_range(0, 3) != 0);
            c_out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        r_valid = 1'b0;
        b_out_ready = 1'b1;
        c_out_ready = 1'b1;
        check("rand_b_ops", {31'd0, b_in_cnt >= 1000}, 1);
        check("rand_c_ops", {31'd0, c_in_cnt >= 1000}, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
